// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if -- SRAM-like data bus between the memory access
// controller (master) and the data memory / bus bridge (slave).
//
// Handshake:
//   data_req is a valid that stays high, with data_wr/size/wstrb/addr/wdata
//   held stable, until a cycle in which data_addr_ok is also high; that
//   cycle transfers the request. data_data_ok is a one-cycle response pulse
//   (read data or write ack) that the master always accepts (no back-pressure).
//
// Signals:
//   data_req      master->slave  request valid
//   data_wr       master->slave  1 = write, 0 = read
//   data_size     master->slave  0 byte, 1 half, 2 word
//   data_wstrb    master->slave  byte write strobes (0 for reads)
//   data_addr     master->slave  byte address
//   data_wdata    master->slave  write data, replicated across lanes
//   data_addr_ok  slave->master  request accepted
//   data_data_ok  slave->master  response / write acknowledge
//   data_rdata    slave->master  read data (full 32-bit word)
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl -- execute-stage load/store unit driving an SRAM-like bus.
// Checks alignment, issues one bus request per load/store, stalls EX while
// the access is outstanding and returns extended load data in a one-cycle
// write-back pulse. A flush kills the access without withdrawing a pending
// request; the response is then drained silently in DROP.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   ex_valid       instruction valid in EX
//   ex_mem_read    load
//   ex_mem_write   store
//   ex_size        0 byte, 1 half, 2 word, 3 illegal
//   ex_unsign      zero-extend load result
//   ex_addr        effective address
//   ex_wdata       store data (LSBs significant)
//   ex_flush       kill in-flight access
//   stall          hold EX stage
//   ale, ale_badv  alignment exception and faulting address (combinational)
//   wb_valid       access complete, one-cycle pulse
//   wb_rdata       extended load data, 0 for stores
//   state_dbg      current FSM state (IDLE 0, REQ 1, WAIT 2, DONE 3, DROP 4)
//   bus            SRAM-like data bus, master side
// ---------------------------------------------------------------------------
module mem_access_ctrl (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsign,
    input  logic [31:0]       ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic              ex_flush,
    output logic              stall,
    output logic              ale,
    output logic [31:0]       ale_badv,
    output logic              wb_valid,
    output logic [31:0]       wb_rdata,
    output logic [2:0]        state_dbg,
    mem_access_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        access;
    logic        misaligned;
    logic        start;
    logic        flushed;     // flush seen while the request was still pending
    logic [3:0]  wstrb_nx;
    logic [31:0] wdata_nx;
    logic [31:0] rdata_shift;
    logic [31:0] load_val;

    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        unsign_q;
    logic        wr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    assign access = ex_mem_read | ex_mem_write;

    always_comb begin
        case (ex_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = ex_addr[0];
            2'd2:    misaligned = (ex_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Alignment is only judged while IDLE; in other states EX is stalled
    // and the instruction on ex_* is the one already being served.
    assign start    = (state == S_IDLE) & ex_valid & access & ~ex_flush & ~misaligned;
    assign ale      = (state == S_IDLE) & ex_valid & access & ~ex_flush &  misaligned;
    assign ale_badv = ale ? ex_addr : 32'd0;

    // Store lane formatting; loads carry no strobes and no data.
    always_comb begin
        wstrb_nx = 4'b0000;
        wdata_nx = 32'd0;
        if (ex_mem_write) begin
            case (ex_size)
                2'd0: begin
                    wstrb_nx = 4'b0001 << ex_addr[1:0];
                    wdata_nx = {4{ex_wdata[7:0]}};
                end
                2'd1: begin
                    wstrb_nx = 4'b0011 << ex_addr[1:0];
                    wdata_nx = {2{ex_wdata[15:0]}};
                end
                default: begin
                    wstrb_nx = 4'b1111;
                    wdata_nx = ex_wdata;
                end
            endcase
        end
    end

    // Halves are 2-aligned, so one byte-granular shift serves both sizes.
    assign rdata_shift = bus.data_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    load_val = unsign_q ? {24'd0, rdata_shift[7:0]}
                                         : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            2'd1:    load_val = unsign_q ? {16'd0, rdata_shift[15:0]}
                                         : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            default: load_val = bus.data_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_REQ;
            // The request is never withdrawn; a flush only redirects to DROP.
            S_REQ:  if (bus.data_addr_ok) state_nx = (flushed | ex_flush) ? S_DROP : S_WAIT;
            S_WAIT: begin
                if (ex_flush) state_nx = bus.data_data_ok ? S_IDLE : S_DROP;
                else if (bus.data_data_ok) state_nx = S_DONE;
            end
            S_DONE: state_nx = S_IDLE;
            S_DROP: if (bus.data_data_ok) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= 32'd0;
            size_q   <= 2'd0;
            unsign_q <= 1'b0;
            wr_q     <= 1'b0;
            wstrb_q  <= 4'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            flushed  <= 1'b0;
        end else begin
            if (start) begin
                addr_q   <= ex_addr;
                size_q   <= ex_size;
                unsign_q <= ex_unsign;
                wr_q     <= ex_mem_write;
                wstrb_q  <= wstrb_nx;
                wdata_q  <= wdata_nx;
                flushed  <= 1'b0;
            end
            if ((state == S_REQ) && ex_flush) begin
                flushed <= 1'b1;
            end
            if ((state == S_WAIT) && bus.data_data_ok && !ex_flush) begin
                rdata_q <= wr_q ? 32'd0 : load_val;
            end
        end
    end

    assign stall      = start | (state == S_REQ) | (state == S_WAIT) | (state == S_DROP);
    assign wb_valid   = (state == S_DONE);
    assign wb_rdata   = rdata_q;
    assign state_dbg  = state;

    assign bus.data_req   = (state == S_REQ);
    assign bus.data_wr    = wr_q;
    assign bus.data_size  = size_q;
    assign bus.data_wstrb = wstrb_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wdata = wdata_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset; the ports are `clk` and `rst`, listed first:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
REQ-002 SHALL have these execute-stage ports:
- ex_valid  in  1  instruction valid in EX
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- ex_unsign  in  1  zero-extend load
- ex_addr  in  32  effective address
- ex_wdata  in  32  store data, LSBs significant
- ex_flush  in  1  kill in-flight access (exception/ertn)
- stall  out  1  hold EX stage
- ale  out  1  address-alignment exception
- ale_badv  out  32  faulting address
- wb_valid  out  1  access complete, one-cycle pulse
- wb_rdata  out  32  extended load data; 0 for stores
REQ-003 SHALL have these SRAM-like bus ports:
- data_req  out  1  request
- data_wr  out  1  1=write
- data_size  out  2  access size
- data_wstrb  out  4  byte strobes
- data_addr  out  32  address
- data_wdata  out  32  write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response/write-ack
- data_rdata  in  32  read data

Function
REQ-004 SHALL define start = ex_valid & (ex_mem_read | ex_mem_write) & ~ex_flush & ~misaligned, evaluated only in IDLE.
REQ-005 SHALL define misaligned as: half with addr[0]=1; word with addr[1:0]!=0; or size=3.
REQ-006 SHALL, in IDLE with ex_valid & access & ~ex_flush & misaligned, assert ale=1 and ale_badv=ex_addr combinationally, issue no request, and keep stall=0.
REQ-007 SHALL implement FSM states IDLE, REQ, WAIT, DONE, DROP.
REQ-008 SHALL make these transitions:
- IDLE->REQ on start, registering addr, size, unsign, wr, strobe and data
- REQ->WAIT on data_addr_ok
- WAIT->DONE on data_data_ok
- DONE->IDLE unconditionally
REQ-009 SHALL assert data_req only in REQ, with all bus outputs driven from registers and held stable until data_addr_ok.
REQ-010 SHALL, on ex_flush in REQ, keep data_req until data_addr_ok (no request withdrawal), then go to DROP.
REQ-011 SHALL, on ex_flush in WAIT, go to DROP; if data_data_ok arrives in the same cycle, go to IDLE instead with no wb_valid.
REQ-012 SHALL leave DROP for IDLE on data_data_ok, discarding data and producing no wb_valid.
REQ-013 SHALL drive stall = (IDLE & start) | REQ | WAIT | DROP; stall=0 in DONE.
REQ-014 SHALL assert wb_valid=1 only in DONE; minimum latency is start at T, data_req at T+1, data_data_ok at T+2, wb_valid at T+3.
REQ-015 SHALL generate strobes as: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-016 SHALL generate data_wdata as: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-017 SHALL form the load result by selecting the byte at addr[1:0] or the half at addr[1], sign- or zero-extended per unsign, and register it into wb_rdata on data_data_ok in WAIT.
REQ-018 SHALL ignore data_addr_ok and data_data_ok in states where they are not expected (IDLE, DONE).

Reset
REQ-019 SHALL, on rst, force state to IDLE and drive every output to 0 (stall, ale, ale_badv, wb_valid, wb_rdata, all data_* outputs) in the following cycle.
REQ-020 SHALL give rst priority over all other inputs; reset mid-access abandons the transaction, and the bus slave shares rst.

Verification
REQ-021 SHALL be verified with:
- ld.b, unsign=0, addr=0x1003, rdata=0x80112233 -> wstrb=0, wb_rdata=0xFFFFFF80 at T+3 with zero-wait bus.
- st.h, addr=0x2002, wdata=0x0000BEEF -> data_wstrb=4'b1100, data_wdata=0xBEEFBEEF, data_wr=1, wb_valid after data_ok.
- ld.w, addr=0x3001 -> ale=1, ale_badv=0x3001, stall=0, data_req never asserted.
- ld.w with data_addr_ok delayed 3 cycles -> data_req and address stable throughout, stall high until DONE.
- ex_flush in WAIT, data_ok 2 cycles later -> state DROP, no wb_valid, next access starts normally.
- rst asserted in WAIT -> all outputs 0 next cycle, FSM IDLE, late data_ok ignored.
